// File: rtl/permute_out_serializer.sv
// permute_out_serializer
// Captures the 64 lane results of the permutation datapath on the rising
// edge of all_done. It then streams them out one lane per valid/ready
// transfer, lane 0 first, while folding every lane into an XOR signature.
// The capture buffer is a plain data store: it is never read outside a
// frame, so it carries no reset.

module permute_out_serializer #(
  parameter int LANES = 64,
  parameter int WIDTH = 25,
  parameter int AW    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   all_done,
  input  logic [LANES*WIDTH-1:0] lanes_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [AW-1:0]          out_idx,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       signature
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0]    IDX_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0]    IDX_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    IDX_LAST  = AW'(LANES - 1);
  localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

  state_t           state_r;
  state_t           state_s;
  logic             all_done_q_r;
  logic [AW-1:0]    idx_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] lane_buf_r [LANES];
  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] signature_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             done_r;

  logic             rise_s;
  logic             capture_s;
  logic             xfer_s;
  logic             last_s;
  logic [AW-1:0]    idx_next_s;
  logic [WIDTH-1:0] cur_word_s;
  logic [WIDTH-1:0] next_word_s;

  // Merge two words into a running XOR signature.
  function automatic logic [WIDTH-1:0] sig_fold(input logic [WIDTH-1:0] sig,
                                                input logic [WIDTH-1:0] word);
    sig_fold = sig ^ word;
  endfunction

  // Edge detect, handshake and current/next lane selection.
  always_comb begin
    rise_s      = all_done & ~all_done_q_r;
    capture_s   = (state_r == ST_IDLE) & rise_s;
    xfer_s      = (state_r == ST_SEND) & out_ready;
    last_s      = (idx_r == IDX_LAST);
    idx_next_s  = idx_r + IDX_ONE;
    cur_word_s  = lane_buf_r[idx_r];
    next_word_s = lane_buf_r[idx_next_s];
  end

  // Next-state logic: a new edge is honoured only from IDLE, and the
  // final transfer replaces the index increment with the move to DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (xfer_s && last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // all_done history; resets high so a level already present at reset
  // release is not mistaken for a completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      all_done_q_r <= 1'b1;
    end else begin
      all_done_q_r <= all_done;
    end
  end

  // Capture buffer: snapshot of every lane on the accepted rising edge.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      for (int i = 0; i < LANES; i++) begin
        lane_buf_r[i] <= lanes_in[WIDTH*i +: WIDTH];
      end
    end
  end

  // Lane index, running XOR, presented word and frame signature.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= IDX_ZERO;
      acc_r       <= WORD_ZERO;
      out_data_r  <= WORD_ZERO;
      signature_r <= WORD_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            idx_r      <= IDX_ZERO;
            acc_r      <= WORD_ZERO;
            out_data_r <= lanes_in[WIDTH-1:0];
          end
        end
        ST_SEND: begin
          if (xfer_s) begin
            acc_r <= sig_fold(acc_r, cur_word_s);
            if (last_s) begin
              signature_r <= sig_fold(acc_r, cur_word_s);
            end else begin
              idx_r      <= idx_next_s;
              out_data_r <= next_word_s;
            end
          end
        end
        ST_DONE: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= IDX_ZERO;
        end
      endcase
    end
  end

  // Status flags registered from the next state so they change together
  // with the state: busy falls exactly when done rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      out_valid_r <= (state_s == ST_SEND);
      busy_r      <= (state_s == ST_SEND);
      done_r      <= (state_s == ST_DONE);
    end
  end

  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign out_data  = out_data_r;
  assign out_idx   = idx_r;
  assign signature = signature_r;

endmodule
